// File: rtl/instruction_fetch.sv
// IF stage: PC register, debug-loadable instruction memory and the IDLE/RUN/HALTED
// fetch sequencer feeding the IF/ID latch.
module instruction_fetch #(
   parameter int          SIZE_DATA  = 32,
   parameter int          SIZE_PC    = 32,
   parameter int          ADDR_W     = 6,
   parameter logic [31:0] HALT_INSTR = 32'hFFFF_FFFF
) (
   input  logic                 i_clk,
   input  logic                 i_reset,
   input  logic                 i_enable,
   input  logic                 i_start,
   input  logic                 i_stall,
   input  logic                 i_pc_src,
   input  logic [SIZE_PC-1:0]   i_pc_target,
   input  logic                 i_wr_en,
   input  logic [ADDR_W-1:0]    i_wr_addr,
   input  logic [SIZE_DATA-1:0] i_wr_data,
   output logic [SIZE_PC-1:0]   o_pc,
   output logic [SIZE_DATA-1:0] o_instr,
   output logic [SIZE_PC-1:0]   o_cur_pc,
   output logic                 o_running,
   output logic                 o_halt
);

   // state      | meaning
   // ST_IDLE    | program load allowed, waiting for i_start, o_instr = NOP
   // ST_RUN     | fetching one word per enabled cycle
   // ST_HALTED  | HALT word fetched, PC frozen until reset
   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_RUN    = 2'd1,
      ST_HALTED = 2'd2
   } state_t;

   state_t               state_q, state_d;
   logic [SIZE_PC-1:0]   pc_q, pc_d;
   logic [SIZE_DATA-1:0] mem_q [0:(1<<ADDR_W)-1];
   logic [SIZE_DATA-1:0] instr;
   logic                 unused_tgt_lsb;

   // Redirect targets are word aligned, so the byte-offset bits are dropped.
   assign unused_tgt_lsb = ^i_pc_target[1:0];

   assign instr     = (state_q == ST_RUN) ? mem_q[pc_q[ADDR_W+1:2]] : '0;
   assign o_instr   = instr;
   assign o_pc      = pc_q + SIZE_PC'(4);
   assign o_cur_pc  = pc_q;
   assign o_running = (state_q == ST_RUN);
   assign o_halt    = (state_q == ST_HALTED);

   always_comb begin
      state_d = state_q;
      pc_d    = pc_q;
      if (i_enable) begin
         case (state_q)
            ST_IDLE: begin
               if (i_start) state_d = ST_RUN;
            end
            ST_RUN: begin
               // A stall discards the redirect; the hazard unit re-asserts it later.
               if (!i_stall) begin
                  if (instr == SIZE_DATA'(HALT_INSTR)) begin
                     state_d = ST_HALTED;
                  end else if (i_pc_src) begin
                     pc_d = {i_pc_target[SIZE_PC-1:2], 2'b00};
                  end else begin
                     pc_d = pc_q + SIZE_PC'(4);
                  end
               end
            end
            default: begin
               state_d = state_q;
            end
         endcase
      end
   end

   always_ff @(posedge i_clk or negedge i_reset) begin
      if (!i_reset) begin
         state_q <= ST_IDLE;
         pc_q    <= '0;
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
      end
   end

   // Program memory survives reset so a reloaded run starts from the same image.
   always_ff @(posedge i_clk) begin
      if (i_wr_en && (state_q == ST_IDLE)) begin
         mem_q[i_wr_addr] <= i_wr_data;
      end
   end

endmodule

// File: tb/tb_instruction_fetch.sv
// Self-checking bench for instruction_fetch: directed scenarios plus a randomized run
// compared against an array-based model of the fetch rules.
module tb_instruction_fetch;
   localparam logic [31:0] HALT = 32'hFFFF_FFFF;

   logic        i_clk = 1'b0;
   logic        i_reset, i_enable, i_start, i_stall, i_pc_src, i_wr_en;
   logic [31:0] i_pc_target, i_wr_data;
   logic [5:0]  i_wr_addr;
   logic [31:0] o_pc, o_instr, o_cur_pc;
   logic        o_running, o_halt;

   int n_checks = 0;
   int n_fail   = 0;

   logic [31:0] m_mem [64];
   logic [31:0] m_pc;
   int          m_st;   // 0 idle, 1 run, 2 halted

   instruction_fetch dut (
      .i_clk(i_clk), .i_reset(i_reset), .i_enable(i_enable), .i_start(i_start),
      .i_stall(i_stall), .i_pc_src(i_pc_src), .i_pc_target(i_pc_target),
      .i_wr_en(i_wr_en), .i_wr_addr(i_wr_addr), .i_wr_data(i_wr_data),
      .o_pc(o_pc), .o_instr(o_instr), .o_cur_pc(o_cur_pc),
      .o_running(o_running), .o_halt(o_halt)
   );

   always #5 i_clk = ~i_clk;

   function automatic logic [31:0] exp_instr();
      return (m_st == 1) ? m_mem[(m_pc / 4) % 64] : 32'h0;
   endfunction

   function automatic logic [97:0] exp_bundle();
      return {m_pc + 32'd4, exp_instr(), m_pc, m_st == 1, m_st == 2};
   endfunction

   function automatic logic [31:0] rnd_word();
      logic [31:0] w;
      w = $urandom;
      if (w == HALT) w = 32'h0;
      return w;
   endfunction

   task automatic tick();
      logic [31:0] ci;
      int          st0;
      ci  = exp_instr();
      st0 = m_st;
      @(posedge i_clk);
      if (i_enable) begin
         if (st0 == 0) begin
            if (i_start) m_st = 1;
         end else if (st0 == 1 && !i_stall) begin
            if (ci == HALT)    m_st = 2;
            else if (i_pc_src) m_pc = i_pc_target & ~32'h3;
            else               m_pc = m_pc + 32'd4;
         end
      end
      if (i_wr_en && st0 == 0) m_mem[i_wr_addr] = i_wr_data;
      #1;
   endtask

   task automatic idle_inputs();
      i_enable = 1'b1; i_start = 1'b0; i_stall = 1'b0; i_pc_src = 1'b0;
      i_pc_target = 32'h0; i_wr_en = 1'b0; i_wr_addr = 6'd0; i_wr_data = 32'h0;
   endtask

   task automatic do_reset();
      i_reset = 1'b0;
      m_pc = 32'h0;
      m_st = 0;
      #2;
      i_reset = 1'b1;
      #1;
   endtask

   task automatic write_word(input int idx, input logic [31:0] data);
      i_wr_en = 1'b1; i_wr_addr = 6'(idx); i_wr_data = data;
      tick();
      i_wr_en = 1'b0;
   endtask

   task automatic jump(input logic [31:0] tgt);
      i_pc_src = 1'b1; i_pc_target = tgt;
      tick();
      i_pc_src = 1'b0;
   endtask

   task automatic test_reset_values();
      n_checks++;
      if ({o_pc, o_instr, o_cur_pc, o_running, o_halt} !== {32'd4, 32'd0, 32'd0, 2'b00}) begin
         n_fail++;
         $display("FAIL reset_values: got pc=%h instr=%h cur=%h run=%b halt=%b want 4/0/0/0/0",
                  o_pc, o_instr, o_cur_pc, o_running, o_halt);
      end
   endtask

   task automatic test_load_run();
      logic [31:0] seq [3];
      seq[0] = 32'h11; seq[1] = 32'h22; seq[2] = HALT;
      do_reset();
      for (int k = 0; k < 3; k++) write_word(k, seq[k]);
      i_start = 1'b1; tick(); i_start = 1'b0;
      for (int k = 0; k < 3; k++) begin
         n_checks++;
         if (o_instr !== seq[k] || o_pc !== 32'(4 * (k + 1)) || o_running !== 1'b1) begin
            n_fail++;
            $display("FAIL load_run_%0d: got instr=%h pc=%h run=%b want %h/%h/1",
                     k, o_instr, o_pc, o_running, seq[k], 4 * (k + 1));
         end
         tick();
      end
      n_checks++;
      if (o_halt !== 1'b1 || o_running !== 1'b0 || o_cur_pc !== 32'h8 || o_instr !== 32'h0) begin
         n_fail++;
         $display("FAIL load_run_halt: got halt=%b run=%b cur=%h instr=%h want 1/0/8/0",
                  o_halt, o_running, o_cur_pc, o_instr);
      end
      write_word(0, 32'hDEAD_BEEF);
      tick();
      n_checks++;
      if (o_halt !== 1'b1 || o_cur_pc !== 32'h8) begin
         n_fail++;
         $display("FAIL halt_hold: got halt=%b cur=%h want 1/8", o_halt, o_cur_pc);
      end
   endtask

   task automatic test_reset_async();
      do_reset();
      i_start = 1'b1; tick(); i_start = 1'b0;
      tick();
      i_reset = 1'b0;
      m_pc = 32'h0; m_st = 0;
      #1;
      n_checks++;
      if ({o_pc, o_instr, o_cur_pc, o_running, o_halt} !== {32'd4, 32'd0, 32'd0, 2'b00}) begin
         n_fail++;
         $display("FAIL reset_async: got pc=%h instr=%h cur=%h run=%b halt=%b want 4/0/0/0/0",
                  o_pc, o_instr, o_cur_pc, o_running, o_halt);
      end
      i_reset = 1'b1;
      #1;
   endtask

   task automatic test_stall_redirect();
      do_reset();
      write_word(2, rnd_word());
      i_start = 1'b1; tick(); i_start = 1'b0;
      tick();
      i_stall = 1'b1; i_pc_src = 1'b1; i_pc_target = 32'h20;
      for (int k = 0; k < 2; k++) begin
         tick();
         n_checks++;
         if (o_cur_pc !== 32'h4 || o_running !== 1'b1) begin
            n_fail++;
            $display("FAIL stall_%0d: got cur=%h run=%b want 4/1", k, o_cur_pc, o_running);
         end
      end
      i_stall = 1'b0;
      jump(32'h23);
      n_checks++;
      if (o_cur_pc !== 32'h20 || o_instr !== m_mem[8]) begin
         n_fail++;
         $display("FAIL redirect: got cur=%h instr=%h want 20/%h", o_cur_pc, o_instr, m_mem[8]);
      end
   endtask

   task automatic test_enable_gating();
      i_enable = 1'b0;
      for (int k = 0; k < 3; k++) begin
         i_stall = 1'($urandom); i_pc_src = 1'($urandom); i_pc_target = $urandom;
         i_start = 1'($urandom);
         tick();
         n_checks++;
         if (o_cur_pc !== 32'h20 || o_running !== 1'b1) begin
            n_fail++;
            $display("FAIL enable_freeze_%0d: got cur=%h run=%b want 20/1", k, o_cur_pc, o_running);
         end
      end
      idle_inputs();
      write_word(0, 32'hCAFE_0000);
      do_reset();
      i_start = 1'b1; tick(); i_start = 1'b0;
      n_checks++;
      if (o_instr !== 32'h11) begin
         n_fail++;
         $display("FAIL run_write_ignored: got instr=%h want 00000011", o_instr);
      end
      do_reset();
      i_enable = 1'b0;
      write_word(5, 32'h5555_AAAA);
      i_start = 1'b1; tick();
      n_checks++;
      if (o_running !== 1'b0) begin
         n_fail++;
         $display("FAIL enable_idle_freeze: got run=%b want 0", o_running);
      end
      i_enable = 1'b1; tick(); i_start = 1'b0;
      jump(32'h14);
      n_checks++;
      if (o_instr !== 32'h5555_AAAA) begin
         n_fail++;
         $display("FAIL write_while_disabled: got instr=%h want 5555aaaa", o_instr);
      end
   endtask

   task automatic test_wrap();
      jump(32'hFC);
      n_checks++;
      if (o_cur_pc !== 32'hFC || o_instr !== m_mem[63]) begin
         n_fail++;
         $display("FAIL wrap_last: got cur=%h instr=%h want fc/%h", o_cur_pc, o_instr, m_mem[63]);
      end
      tick();
      n_checks++;
      if (o_cur_pc !== 32'h100 || o_instr !== 32'h11 || o_pc !== 32'h104) begin
         n_fail++;
         $display("FAIL wrap_index: got cur=%h instr=%h pc=%h want 100/11/104", o_cur_pc, o_instr, o_pc);
      end
      jump(32'h1234_5677);
      n_checks++;
      if (o_cur_pc !== 32'h1234_5674 || o_instr !== m_mem[29]) begin
         n_fail++;
         $display("FAIL far_target: got cur=%h instr=%h want 12345674/%h", o_cur_pc, o_instr, m_mem[29]);
      end
   endtask

   task automatic test_halt_priority();
      do_reset();
      write_word(10, HALT);
      i_start = 1'b1; tick(); i_start = 1'b0;
      jump(32'h28);
      jump(32'h4);
      n_checks++;
      if (o_halt !== 1'b1 || o_cur_pc !== 32'h28 || o_instr !== 32'h0) begin
         n_fail++;
         $display("FAIL halt_over_branch: got halt=%b cur=%h instr=%h want 1/28/0", o_halt, o_cur_pc, o_instr);
      end
   endtask

   task automatic test_start_write();
      do_reset();
      i_wr_en = 1'b1; i_wr_addr = 6'd3; i_wr_data = 32'h3333_3333; i_start = 1'b1;
      tick();
      i_wr_en = 1'b0; i_start = 1'b0;
      n_checks++;
      if (o_running !== 1'b1) begin
         n_fail++;
         $display("FAIL start_with_write: got run=%b want 1", o_running);
      end
      jump(32'hC);
      n_checks++;
      if (o_instr !== 32'h3333_3333) begin
         n_fail++;
         $display("FAIL start_write_lands: got instr=%h want 33333333", o_instr);
      end
   endtask

   task automatic test_random();
      logic [97:0] exp;
      int          halted_cycles = 0;
      do_reset();
      for (int k = 0; k < 2000; k++) begin
         i_enable    = ($urandom % 8) != 0;
         i_start     = ($urandom % 4) == 0;
         i_stall     = ($urandom % 5) == 0;
         i_pc_src    = ($urandom % 4) == 0;
         i_pc_target = ($urandom % 4 == 0) ? $urandom : 32'($urandom_range(0, 255));
         i_wr_en     = ($urandom % 3) == 0;
         i_wr_addr   = 6'($urandom);
         i_wr_data   = ($urandom % 6 == 0) ? HALT : $urandom;
         tick();
         exp = exp_bundle();
         n_checks++;
         if ({o_pc, o_instr, o_cur_pc, o_running, o_halt} !== exp) begin
            n_fail++;
            $display("FAIL random_%0d: got %h want %h", k,
                     {o_pc, o_instr, o_cur_pc, o_running, o_halt}, exp);
         end
         halted_cycles = (m_st == 2) ? halted_cycles + 1 : 0;
         if (halted_cycles > 3 || ($urandom % 100) == 0) begin
            do_reset();
            halted_cycles = 0;
         end
      end
      idle_inputs();
   endtask

   initial begin
      #2_000_000;
      n_fail++;
      $display("FAIL watchdog: simulation time limit reached");
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $fatal(1);
   end

   initial begin
      idle_inputs();
      i_reset = 1'b0;
      m_pc = 32'h0;
      m_st = 0;
      repeat (2) @(posedge i_clk);
      #1;
      test_reset_values();
      i_reset = 1'b1;
      #1;
      for (int i = 0; i < 64; i++) write_word(i, rnd_word());
      test_load_run();
      test_reset_async();
      test_stall_redirect();
      test_enable_gating();
      test_wrap();
      test_halt_priority();
      test_start_write();
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
